data_mem_rmw_ctrl: RTL

DATA_MEM_RMW_CTRL -- requirements
Module: data_mem_rmw_ctrl

---
 rtl/data_mem_rmw_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/data_mem_rmw_ctrl.sv
// Data-memory access controller: sequences loads, read-modify-write sub-word
// stores and direct word stores against a synchronous SRAM.
// Optional misalignment trap: define DATA_MEM_MISALIGN_TRAP_EN.
module data_mem_rmw_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_sign_mask,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_busy,
  output logic              cpu_fault,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        mux_addr_lsb,
  output logic [31:0]       mux_word_buf,
  output logic [31:0]       mux_write_data,
  output logic [3:0]        mux_sign_mask,
  input  logic [31:0]       mux_read_buf,
  input  logic [31:0]       mux_replacement_word
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    ACK
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          mask_q, mask_d;
  logic                store_q, store_d;
  logic                fault_q, fault_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                req;
  logic                req_is_word;
  logic                misalign;
  logic                load_done;

  assign req         = cpu_memread | cpu_memwrite;
  assign req_is_word = (cpu_sign_mask[2:1] == 2'b11);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (cpu_sign_mask[2:1] == 2'b01 && cpu_addr[0])
      misalign = 1'b1;
    if (req_is_word && cpu_addr[1:0] != 2'b00)
      misalign = 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

  // A load completing in ACK: the lane mux result is live this cycle.
  assign load_done = (state_q == ACK) && !store_q && !fault_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    store_d = store_q;
    fault_d = fault_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          mask_d  = cpu_sign_mask;
          store_d = cpu_memwrite;
          fault_d = misalign;
          if (misalign)
            state_d = ACK;
          else if (cpu_memwrite && req_is_word)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        word_d  = mem_rdata;
        state_d = store_q ? WR : ACK;
      end
      WR:  state_d = ACK;
      ACK: begin
        if (load_done)
          rdata_d = mux_read_buf;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      store_q <= 1'b0;
      fault_q <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      store_q <= store_d;
      fault_q <= fault_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    cpu_busy  = (state_q != IDLE);
    cpu_ack   = (state_q == ACK);
    cpu_fault = (state_q == ACK) && fault_q;
    mem_rd_en = (state_q == RD);
    mem_wr_en = (state_q == WR);
    mem_wdata = '0;
    if (state_q == WR)
      mem_wdata = (mask_q[2:1] == 2'b11) ? wdata_q : mux_replacement_word;
    // The word register only settles at the CAP->ACK edge, so the load result
    // is forwarded from the mux during ACK and held in rdata_q afterwards.
    cpu_rdata = load_done ? mux_read_buf : rdata_q;
  end

  assign mem_addr       = addr_q[ADDR_W-1:2];
  assign mux_addr_lsb   = addr_q[1:0];
  assign mux_word_buf   = word_q;
  assign mux_write_data = wdata_q;
  assign mux_sign_mask  = mask_q;

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rd_en && mem_wr_en));
  a_ack_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
    cpu_ack |-> cpu_busy);

endmodule
